// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_pkg
//  Brief    : State encoding, default parameters and counter sizing helper
//             shared by the reset sequencer and its synchronizer.
//  Revision : 1.0
// ============================================================================
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_HOLD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int c_default_sync_stages = 2;
   localparam int c_default_hold_cycles = 4;
   localparam int c_default_run_cycles  = 10;
   localparam int c_default_cw          = 32;

   // Counter width able to hold 0..n-1; never below one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sync
//  Brief    : Asynchronous-assert, synchronous-release reset synchronizer.
//  Revision : 1.0
// ============================================================================
module reset_sync
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = c_default_sync_stages
) (
   input  logic clk,
   input  logic rst,
   output logic sync_rel
);

   logic [SYNC_STAGES-1:0] r_sync;

   // A one ripples in after release; rst clears every stage at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_rel = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Brief    : Sequences reset release, a HOLD period and a bounded RUN window,
//             then flags done; restart re-issues reset from RUN or DONE.
//  Revision : 1.0
// ============================================================================
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = c_default_sync_stages,
   parameter int HOLD_CYCLES = c_default_hold_cycles,
   parameter int RUN_CYCLES  = c_default_run_cycles,
   parameter int CW          = c_default_cw
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          restart,
   output logic          rst_out,
   output logic          running,
   output logic          done,
   output logic [CW-1:0] cycle_count
);

   localparam int c_hold_w = cnt_width(HOLD_CYCLES);
   localparam int c_run_w  = cnt_width(RUN_CYCLES);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
   localparam logic [c_run_w-1:0]  c_run_last  = c_run_w'(RUN_CYCLES - 1);

   logic                w_sync_rel;
   state_t              r_state;
   logic [c_hold_w-1:0] r_hold_cnt;
   logic [c_run_w-1:0]  r_run_cnt;
   logic                r_rst_out;
   logic                r_running;
   logic                r_done;
   logic [CW-1:0]       r_cycle_count;

   reset_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_reset_sync (
      .clk      (clk),
      .rst      (rst),
      .sync_rel (w_sync_rel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RESET;
         r_hold_cnt    <= '0;
         r_run_cnt     <= '0;
         r_rst_out     <= 1'b1;
         r_running     <= 1'b0;
         r_done        <= 1'b0;
         r_cycle_count <= '0;
      end else begin
         if (r_state != ST_RESET) begin
            r_cycle_count <= r_cycle_count + CW'(1);
         end

         case (r_state)
            ST_RESET: begin
               if (w_sync_rel) begin
                  r_state    <= ST_HOLD;
                  r_hold_cnt <= '0;
               end
            end

            ST_HOLD: begin
               if (r_hold_cnt == c_hold_last) begin
                  r_state   <= ST_RUN;
                  r_rst_out <= 1'b0;
                  r_running <= 1'b1;
                  r_run_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
               end
            end

            // restart is checked first so it beats a completing RUN window.
            ST_RUN: begin
               if (restart) begin
                  r_state    <= ST_HOLD;
                  r_rst_out  <= 1'b1;
                  r_running  <= 1'b0;
                  r_done     <= 1'b0;
                  r_hold_cnt <= '0;
               end else if (RUN_CYCLES != 0) begin
                  if (r_run_cnt == c_run_last) begin
                     r_state   <= ST_DONE;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_run_cnt <= r_run_cnt + c_run_w'(1);
                  end
               end
            end

            ST_DONE: begin
               if (restart) begin
                  r_state    <= ST_HOLD;
                  r_rst_out  <= 1'b1;
                  r_running  <= 1'b0;
                  r_done     <= 1'b0;
                  r_hold_cnt <= '0;
               end
            end

            default: begin
               r_state <= ST_RESET;
            end
         endcase
      end
   end

   assign rst_out     = r_rst_out;
   assign running     = r_running;
   assign done        = r_done;
   assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
